byte_decode_stream: RTL and testbench

Streaming ML-KEM ByteDecode_d stage. It accepts an encoded polynomial one byte per handshake and unpacks it LSB-first into 256 d-bit coefficients. For d=12 it also reduces each coefficient mod q=3329. It sits between the byte-oriented key/ciphertext input path and the coefficient-domain arithmetic (decompress/NTT). It is the sequential counterpart of the combinational `byte_decode`, and its output must match that block bit-exactly.

---
 rtl/kyber_pkg.sv | 17 +
 rtl/byte_decode_bitbuf.sv | 50 +++++
 rtl/byte_decode_stream.sv | 143 ++++++++++++++
 tb/tb_byte_decode_stream.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kyber_pkg.sv
// rtl/kyber_pkg.sv - shared ML-KEM constants, decoder state type and sizing helper
package kyber_pkg;

   localparam int KYBER_Q = 3329;
   localparam int KYBER_N = 256;
   localparam int MAX_D   = 12;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } dec_state_t;

   function automatic int bytes_per_poly(input int d);
      return 32 * d;
   endfunction

endpackage

// File: rtl/byte_decode_bitbuf.sv
// rtl/byte_decode_bitbuf.sv - D+8 bit LSB-first shift buffer with fill count
// Extract (shift) is applied before append so a byte lands just above the surviving bits.
module byte_decode_bitbuf
#(
   parameter int D  = 12,
   parameter int CW = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear,
   input  logic          shift,
   input  logic          append,
   input  logic [7:0]    din,
   output logic [D-1:0]  data,
   output logic [CW-1:0] cnt,
   output logic [CW-1:0] cnt_after
);

   localparam int W = D + 8;

   logic [W-1:0]  sbuf_q;
   logic [W-1:0]  shifted;
   logic [CW-1:0] cnt_q;

   always_comb begin
      shifted   = shift ? (sbuf_q >> D) : sbuf_q;
      cnt_after = shift ? (cnt_q - CW'(D)) : cnt_q;
   end

   // Bits above cnt are always zero, so OR-ing the new byte in is safe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sbuf_q <= '0;
         cnt_q  <= '0;
      end else if (clear) begin
         sbuf_q <= '0;
         cnt_q  <= '0;
      end else if (append) begin
         sbuf_q <= shifted | (W'(din) << cnt_after);
         cnt_q  <= cnt_after + CW'(8);
      end else begin
         sbuf_q <= shifted;
         cnt_q  <= cnt_after;
      end
   end

   assign data = sbuf_q[D-1:0];
   assign cnt  = cnt_q;

endmodule

// File: rtl/byte_decode_stream.sv
// rtl/byte_decode_stream.sv - streaming ByteDecode_d: bytes in, 256 D-bit coefficients out
// Optional macro BYTE_DECODE_MODQ_CHECK_EN adds the sticky coefficient >= Q flag for D=12.
module byte_decode_stream
   import kyber_pkg::*;
#(
   parameter int D = 12,
   parameter int Q = KYBER_Q
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start_i,
   input  logic         byte_valid_i,
   input  logic [7:0]   byte_i,
   output logic         byte_ready_o,
   output logic         coef_valid_o,
   output logic [D-1:0] coef_o,
   output logic         coef_last_o,
   input  logic         coef_ready_i,
   output logic         done_o,
   output logic         err_o
);

   localparam int            CW         = $clog2(D + 9);
   localparam logic [CW-1:0] D_C        = CW'(D);
   localparam logic [8:0]    BYTES_INIT = 9'(bytes_per_poly(D));
   localparam logic [8:0]    COEFS_INIT = 9'(KYBER_N);

   dec_state_t    state_q;
   dec_state_t    state_d;
   logic          run;
   logic          hs;
   logic          last_hs;
   logic          emit;
   logic          accept;
   logic [8:0]    bytes_left_q;
   logic [8:0]    coefs_left_q;
   logic [D-1:0]  raw;
   logic [D-1:0]  reduced;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_after;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start_i) state_d = ST_RUN;
         ST_RUN: begin
            if (start_i)      state_d = ST_RUN;
            else if (last_hs) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      run     = (state_q == ST_RUN);
      hs      = coef_valid_o && coef_ready_i;
      last_hs = hs && coef_last_o;
   end

   // Readiness looks at the fill count after this cycle's extract, hence the path from coef_ready_i.
   assign emit         = run && (cnt >= D_C) && (coefs_left_q != 9'd0) && (!coef_valid_o || coef_ready_i);
   assign byte_ready_o = run && (bytes_left_q != 9'd0) && (cnt_after <= D_C);
   assign accept       = byte_valid_i && byte_ready_o;

   byte_decode_bitbuf #(
      .D  (D),
      .CW (CW)
   ) u_bitbuf (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (start_i),
      .shift     (emit),
      .append    (accept),
      .din       (byte_i),
      .data      (raw),
      .cnt       (cnt),
      .cnt_after (cnt_after)
   );

   generate
      if (D == MAX_D) begin : g_reduce
         localparam logic [D-1:0] Q_C = D'(Q);
         assign reduced = (raw >= Q_C) ? (raw - Q_C) : raw;
      end else begin : g_pass
         assign reduced = raw;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bytes_left_q <= '0;
         coefs_left_q <= '0;
         coef_valid_o <= 1'b0;
         coef_o       <= '0;
         coef_last_o  <= 1'b0;
         done_o       <= 1'b0;
      end else if (start_i) begin
         bytes_left_q <= BYTES_INIT;
         coefs_left_q <= COEFS_INIT;
         coef_valid_o <= 1'b0;
         coef_o       <= '0;
         coef_last_o  <= 1'b0;
         done_o       <= 1'b0;
      end else begin
         done_o <= last_hs;
         if (accept) bytes_left_q <= bytes_left_q - 9'd1;
         if (emit) begin
            coef_valid_o <= 1'b1;
            coef_o       <= reduced;
            coef_last_o  <= (coefs_left_q == 9'd1);
            coefs_left_q <= coefs_left_q - 9'd1;
         end else if (hs) begin
            coef_valid_o <= 1'b0;
            coef_last_o  <= 1'b0;
         end
      end
   end

`ifdef BYTE_DECODE_MODQ_CHECK_EN
   generate
      if (D == MAX_D) begin : g_modq_chk
         localparam logic [D-1:0] QCHK = D'(Q);
         logic err_q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                      err_q <= 1'b0;
            else if (start_i)                err_q <= 1'b0;
            else if (emit && (raw >= QCHK))  err_q <= 1'b1;
         end
         assign err_o = err_q;
      end else begin : g_no_chk
         assign err_o = 1'b0;
      end
   endgenerate
`else
   assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_byte_decode_stream.sv
// tb/tb_byte_decode_stream.sv - scoreboard bench for byte_decode_stream at D=1, 8 and 12
module tb_byte_decode_stream;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        start      [3];
   logic        byte_valid [3];
   logic [7:0]  din        [3];
   logic        coef_ready [3];
   logic        byte_ready [3];
   logic        coef_valid [3];
   logic        coef_last  [3];
   logic        done       [3];
   logic        err        [3];
   logic [0:0]  coef_d1;
   logic [7:0]  coef_d8;
   logic [11:0] coef_d12;
   logic [11:0] coef_w     [3];

   assign coef_w[0] = {11'd0, coef_d1};
   assign coef_w[1] = {4'd0, coef_d8};
   assign coef_w[2] = coef_d12;

`ifdef BYTE_DECODE_MODQ_CHECK_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif

   int         tests;
   int         fails;
   logic [7:0] tx_q [$];
   int         exp_q [$];

   byte_decode_stream #(.D(1)) u_d1 (
      .clk(clk), .rst_n(rst_n), .start_i(start[0]), .byte_valid_i(byte_valid[0]), .byte_i(din[0]),
      .byte_ready_o(byte_ready[0]), .coef_valid_o(coef_valid[0]), .coef_o(coef_d1),
      .coef_last_o(coef_last[0]), .coef_ready_i(coef_ready[0]), .done_o(done[0]), .err_o(err[0]));

   byte_decode_stream #(.D(8)) u_d8 (
      .clk(clk), .rst_n(rst_n), .start_i(start[1]), .byte_valid_i(byte_valid[1]), .byte_i(din[1]),
      .byte_ready_o(byte_ready[1]), .coef_valid_o(coef_valid[1]), .coef_o(coef_d8),
      .coef_last_o(coef_last[1]), .coef_ready_i(coef_ready[1]), .done_o(done[1]), .err_o(err[1]));

   byte_decode_stream #(.D(12)) u_d12 (
      .clk(clk), .rst_n(rst_n), .start_i(start[2]), .byte_valid_i(byte_valid[2]), .byte_i(din[2]),
      .byte_ready_o(byte_ready[2]), .coef_valid_o(coef_valid[2]), .coef_o(coef_d12),
      .coef_last_o(coef_last[2]), .coef_ready_i(coef_ready[2]), .done_o(done[2]), .err_o(err[2]));

   function automatic int dval(input int s);
      return (s == 0) ? 1 : ((s == 1) ? 8 : 12);
   endfunction

   // Reference ByteEncode: raw coefficients packed LSB-first; expected values reduced mod q for D=12.
   task automatic load_poly(input int s, input bit ones);
      int d, bitpos, raw, ev;
      logic [7:0] acc;
      d = dval(s); bitpos = 0; acc = '0;
      for (int i = 0; i < 256; i++) begin
         raw = ones ? ((1 << d) - 1) : ((d == 12) ? (i % 3329) : (i % (1 << d)));
         ev  = (d == 12 && raw >= 3329) ? (raw - 3329) : raw;
         exp_q.push_back(ev);
         for (int k = 0; k < d; k++) begin
            acc[bitpos % 8] = raw[k];
            bitpos++;
            if (bitpos % 8 == 0) begin
               tx_q.push_back(acc);
               acc = '0;
            end
         end
      end
   endtask

   task automatic pulse_start(input int s);
      @(negedge clk);
      start[s] = 1'b1; byte_valid[s] = 1'b0; coef_ready[s] = 1'b0;
      @(negedge clk);
      start[s] = 1'b0;
      #1;
      tests++;
      if (byte_ready[s] !== 1'b1) begin
         fails++;
         $display("FAIL start_ready s=%0d: got %b, need 1", s, byte_ready[s]);
      end
   endtask

   task automatic stream(input int s, input int pct, input int stop_at, input int budget,
                         output int ncoef, output int ndone, output int last_cyc);
      int d, cyc, post, acc, cnt_m, ev;
      bit stalled;
      logic [11:0] held_coef;
      logic held_last, exp_rdy;
      d = dval(s); ncoef = 0; ndone = 0; last_cyc = 0; cyc = 0; post = 0; acc = 0; cnt_m = 0;
      stalled = 1'b0; held_coef = '0; held_last = 1'b0;
      while (cyc < budget && post < 4) begin
         @(negedge clk);
         cyc++;
         byte_valid[s] = (tx_q.size() != 0);
         din[s]        = (tx_q.size() != 0) ? tx_q[0] : 8'h00;
         coef_ready[s] = (int'($urandom_range(99)) < pct);
         #1;
         if (done[s] === 1'b1) ndone++;
         if (stalled) begin
            tests++;
            if (coef_valid[s] !== 1'b1 || coef_w[s] !== held_coef || coef_last[s] !== held_last) begin
               fails++;
               $display("FAIL stall_hold s=%0d cyc=%0d: got v=%b c=%0d l=%b, need v=1 c=%0d l=%b",
                        s, cyc, coef_valid[s], coef_w[s], coef_last[s], held_coef, held_last);
            end
         end
         if (coef_valid[s] === 1'b1 && coef_ready[s] === 1'b0) begin
            exp_rdy = (acc < 32 * d) && (cnt_m - d <= d);
            tests++;
            if (byte_ready[s] !== exp_rdy) begin
               fails++;
               $display("FAIL ready_stall s=%0d cyc=%0d: got %b, need %b", s, cyc, byte_ready[s], exp_rdy);
            end
         end
         if (byte_valid[s] && byte_ready[s] === 1'b1) begin
            void'(tx_q.pop_front());
            acc++;
            cnt_m += 8;
         end
         stalled   = (coef_valid[s] === 1'b1) && !coef_ready[s];
         held_coef = coef_w[s];
         held_last = coef_last[s];
         if (coef_valid[s] === 1'b1 && coef_ready[s]) begin
            ev = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
            tests++;
            if (coef_w[s] !== 12'(ev) || coef_last[s] !== (ncoef == 255)) begin
               fails++;
               $display("FAIL coef s=%0d idx=%0d: got %0d last=%b, need %0d last=%b",
                        s, ncoef, coef_w[s], coef_last[s], ev, (ncoef == 255));
            end
            ncoef++;
            cnt_m -= d;
            if (ncoef == 256) last_cyc = cyc;
            if (ncoef == stop_at) break;
         end
         if (ncoef >= 256) post++;
      end
      @(negedge clk);
      byte_valid[s] = 1'b0;
      coef_ready[s] = 1'b0;
   endtask

   task automatic check_poly_end(input int s, input int ncoef, input int ndone);
      tests++;
      if (ncoef !== 256 || ndone !== 1 || exp_q.size() !== 0) begin
         fails++;
         $display("FAIL poly_end s=%0d: got coefs=%0d done=%0d left=%0d, need 256 1 0",
                  s, ncoef, ndone, exp_q.size());
      end
   endtask

   task automatic test_reset;
      #12;
      for (int s = 0; s < 3; s++) begin
         tests++;
         if ({byte_ready[s], coef_valid[s], coef_last[s], done[s], err[s]} !== 5'b0 || coef_w[s] !== 12'd0) begin
            fails++;
            $display("FAIL reset_vals s=%0d: got rdy=%b v=%b c=%0d l=%b d=%b e=%b, need all 0",
                     s, byte_ready[s], coef_valid[s], coef_w[s], coef_last[s], done[s], err[s]);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      byte_valid[0] = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      tests++;
      if (byte_ready[0] !== 1'b0) begin
         fails++;
         $display("FAIL idle_ready: got %b, need 0", byte_ready[0]);
      end
      byte_valid[0] = 1'b0;
   endtask

   task automatic test_d1_pattern;
      int nc, nd, lc;
      tx_q.push_back(8'hA5);
      for (int i = 0; i < 31; i++) tx_q.push_back(8'h00);
      tx_q.push_back(8'hFF);
      for (int i = 0; i < 8; i++) exp_q.push_back((8'hA5 >> i) & 1);
      for (int i = 0; i < 248; i++) exp_q.push_back(0);
      pulse_start(0);
      stream(0, 100, -1, 600, nc, nd, lc);
      check_poly_end(0, nc, nd);
      tests++;
      if (tx_q.size() !== 1) begin
         fails++;
         $display("FAIL extra_byte: got %0d bytes left, need 1", tx_q.size());
      end
      tx_q.delete();
   endtask

   task automatic test_d12_vectors;
      int nc, nd, lc;
      tx_q = '{8'h01, 8'hD0, 8'h00, 8'hFF, 8'hFF, 8'hFF};
      for (int i = 0; i < 378; i++) tx_q.push_back(8'h00);
      exp_q = '{1, 13, 766, 766};
      for (int i = 0; i < 252; i++) exp_q.push_back(0);
      pulse_start(2);
      stream(2, 100, -1, 800, nc, nd, lc);
      check_poly_end(2, nc, nd);
      tests++;
      if (err[2] !== EXP_ERR) begin
         fails++;
         $display("FAIL err_vec: got %b, need %b", err[2], EXP_ERR);
      end
   endtask

   task automatic test_full_poly;
      int nc, nd, lc, bound;
      for (int s = 0; s < 3; s++) begin
         load_poly(s, 1'b0);
         pulse_start(s);
         stream(s, 100, -1, 1000, nc, nd, lc);
         check_poly_end(s, nc, nd);
         bound = ((32 * dval(s) > 256) ? 32 * dval(s) : 256) + 6;
         tests++;
         if (lc > bound || err[s] !== 1'b0) begin
            fails++;
            $display("FAIL throughput s=%0d: got %0d cycles err=%b, need <=%0d err=0", s, lc, err[s], bound);
         end
      end
   endtask

   task automatic test_backpressure;
      int nc, nd, lc;
      load_poly(2, 1'b0);
      pulse_start(2);
      stream(2, 30, -1, 6000, nc, nd, lc);
      check_poly_end(2, nc, nd);
   endtask

   task automatic test_abort;
      int nc, nd, lc;
      load_poly(2, 1'b1);
      pulse_start(2);
      stream(2, 100, 100, 2000, nc, nd, lc);
      tests++;
      if (nc !== 100 || nd !== 0 || err[2] !== EXP_ERR) begin
         fails++;
         $display("FAIL abort_pre: got coefs=%0d done=%0d err=%b, need 100 0 %b", nc, nd, err[2], EXP_ERR);
      end
      tx_q.delete();
      exp_q.delete();
      pulse_start(2);
      tests++;
      if (coef_valid[2] !== 1'b0 || err[2] !== 1'b0) begin
         fails++;
         $display("FAIL abort_clear: got v=%b err=%b, need 0 0", coef_valid[2], err[2]);
      end
      load_poly(2, 1'b0);
      stream(2, 70, -1, 3000, nc, nd, lc);
      check_poly_end(2, nc, nd);
   endtask

   task automatic test_reset_mid_run;
      pulse_start(1);
      @(negedge clk);
      byte_valid[1] = 1'b1; din[1] = 8'hC3; coef_ready[1] = 1'b0;
      @(negedge clk);
      byte_valid[1] = 1'b0;
      @(negedge clk);
      #1;
      tests++;
      if (coef_valid[1] !== 1'b1 || coef_w[1] !== 12'h0C3) begin
         fails++;
         $display("FAIL pre_reset: got v=%b c=%0h, need 1 c3", coef_valid[1], coef_w[1]);
      end
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      tests++;
      if ({byte_ready[1], coef_valid[1], coef_last[1], done[1], err[1]} !== 5'b0 || coef_w[1] !== 12'd0) begin
         fails++;
         $display("FAIL async_reset: got rdy=%b v=%b c=%0h, need 0 0 0", byte_ready[1], coef_valid[1], coef_w[1]);
      end
      @(negedge clk);
      rst_n = 1'b1;
      byte_valid[1] = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      tests++;
      if (byte_ready[1] !== 1'b0 || coef_valid[1] !== 1'b0) begin
         fails++;
         $display("FAIL post_reset_idle: got rdy=%b v=%b, need 0 0", byte_ready[1], coef_valid[1]);
      end
      byte_valid[1] = 1'b0;
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst_n = 1'b0;
      for (int s = 0; s < 3; s++) begin
         start[s] = 1'b0; byte_valid[s] = 1'b0; din[s] = 8'h00; coef_ready[s] = 1'b0;
      end
      test_reset;
      test_d1_pattern;
      test_d12_vectors;
      test_full_poly;
      test_backpressure;
      test_abort;
      test_reset_mid_run;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
